inv_sub_bytes_iter: RTL and testbench

//   Iterative AES InvSubBytes engine for the decryption datapath.

---
 rtl/inv_sub_bytes_iter.sv | 132 +++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: a 128-bit state is substituted LANES bytes per cycle
// through LANES combinational inverse S-boxes, with valid/ready on both sides.

module inv_sbox (
  input  logic [7:0] in_bus,
  output logic [7:0] out_bus
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] pre;

  // Undo the forward affine transform, then invert in GF(2^8).
  always_comb begin
    pre = {in_bus[6:0], in_bus[7]} ^ {in_bus[4:0], in_bus[7:5]} ^
          {in_bus[1:0], in_bus[7:2]} ^ 8'h05;
    out_bus = gf_inv(pre);
  end

endmodule

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus,
  output logic         busy
);

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  int              base;

  assign base = int'(cnt_q) * LANES;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = work_q[(base + l) * 8 +: 8];
    inv_sbox u_inv_sbox (.in_bus(lane_in[l]), .out_bus(lane_out[l]));
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_bus;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) work_d[(base + l) * 8 +: 8] = lane_out[l];
        if (cnt_q == CW'(NSTEP - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: work_q drives out_bus directly, so it must be reset for out_bus to read 0 out of reset.
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign out_bus = work_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboarded bench: five instances (LANES 1,2,4,8,16) share stimulus; a per-instance
// monitor pushes the reference result on accept and checks data and latency on output.

module tb_inv_sub_bytes_iter;

  localparam int ND   = 5;
  localparam int MAIN = 2;   // LANES=4 instance

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_bus;
  logic [ND-1:0] in_ready, out_valid, busy;
  logic [127:0] out_bus [ND];

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  bit b2b    = 1'b0;

  logic [127:0] exp_q [ND][$];
  int  acc_edge  [ND];
  int  acc_count [ND];
  bit  have_acc  [ND];
  bit  ov_prev   [ND];

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: forward S-box from its definition (brute-force inverse + affine), then inverted.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = (x ^ 'h11b);
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && mul(x[7:0], y[7:0]) == 8'h01) b = y[7:0];
      fwd_tab[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = x[7:0];
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[s[8*i +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << g)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .in_bus   (in_bus),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_bus  (out_bus[g]),
      .busy     (busy[g])
    );

    always @(negedge clk) begin
      if (rst) begin
        exp_q[g].delete();
        ov_prev[g]  = 1'b0;
        have_acc[g] = 1'b0;
      end else begin
        if (out_valid[g] && !ov_prev[g])
          check($sformatf("latency[L%0d]", 1 << g), 128'(cyc - acc_edge[g]), 128'(16 >> g));
        ov_prev[g] = out_valid[g];
        if (out_valid[g] && out_ready) begin
          if (exp_q[g].size() == 0)
            check($sformatf("unexpected_out[L%0d]", 1 << g), out_bus[g], 128'hx);
          else
            check($sformatf("data[L%0d]", 1 << g), out_bus[g], exp_q[g].pop_front());
        end
        if (in_valid && in_ready[g]) begin
          if (b2b && have_acc[g])
            check($sformatf("interval[L%0d]", 1 << g), 128'(cyc + 1 - acc_edge[g]), 128'((16 >> g) + 2));
          acc_edge[g]  = cyc + 1;
          have_acc[g]  = 1'b1;
          acc_count[g] = acc_count[g] + 1;
          exp_q[g].push_back(ref_inv(in_bus));
        end
      end
    end
  end

  task automatic send(input logic [127:0] d);
    in_bus   = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (&in_ready) ok = 1'b1;
    end
    if (!ok) check("wait_idle_timeout", 128'(in_ready), 128'h1f);
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid[idx]) ok = 1'b1;
    end
    if (!ok) check("wait_out_timeout", 128'(out_valid[idx]), 128'h1);
  endtask

  initial begin
    logic [127:0] x, y;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_bus = '0;
    for (int g = 0; g < ND; g++) begin acc_edge[g] = 0; acc_count[g] = 0; end
    build_tables();
    #12;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("rst_in_ready[L%0d]", 1 << g), 128'(in_ready[g]), 128'h1);
      check($sformatf("rst_out_valid[L%0d]", 1 << g), 128'(out_valid[g]), 128'h0);
      check($sformatf("rst_busy[L%0d]", 1 << g), 128'(busy[g]), 128'h0);
      check($sformatf("rst_out_bus[L%0d]", 1 << g), out_bus[g], 128'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // T1: all 0x63 -> all zero
    send({16{8'h63}});
    wait_out(MAIN);
    check("t1_value", out_bus[MAIN], 128'h0);
    wait_idle();

    // T2: byte order with known InvSbox pairs
    send({{12{8'h63}}, 8'h7c, 8'h16, 8'h01, 8'h00});
    wait_out(MAIN);
    check("t2_bytes", out_bus[MAIN], {{12{8'h00}}, 8'h01, 8'hff, 8'h09, 8'h52});
    wait_idle();

    // T3: random round trip through the forward S-box
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(ref_fwd(x));
      wait_out(0);
      check("t3_roundtrip", out_bus[0], x);
      wait_idle();
    end

    // T4: backpressure in DONE with a held in_valid
    out_ready = 1'b0;
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(x);
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_bus   = ~x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_out_bus_stable", out_bus[MAIN], ref_inv(x));
      check("t4_out_valid", 128'(out_valid[MAIN]), 128'h1);
      check("t4_in_ready", 128'(in_ready[MAIN]), 128'h0);
      check("t4_busy", 128'(busy[MAIN]), 128'h1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release_in_ready", 128'(in_ready[MAIN]), 128'h1);
    check("t4_release_out_valid", 128'(out_valid[MAIN]), 128'h0);
    wait_idle();

    // T5: reset while the LANES=2 instance is at cnt=2
    send({$urandom(), $urandom(), $urandom(), $urandom()});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 128'(out_valid[1]), 128'h0);
    check("t5_in_ready", 128'(in_ready[1]), 128'h1);
    check("t5_out_bus", out_bus[1], 128'h0);
    check("t5_busy", 128'(busy[1]), 128'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    y = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(ref_fwd(y));
    wait_out(1);
    check("t5_after_reset", out_bus[1], y);
    wait_idle();

    // T6: back-to-back with in_valid and out_ready held high
    for (int g = 0; g < ND; g++) begin have_acc[g] = 1'b0; acc_count[g] = 0; end
    b2b      = 1'b1;
    in_valid = 1'b1;
    in_bus   = ref_fwd({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (17 * 18 - 1) begin
      @(posedge clk); #1;
      in_bus = ref_fwd({$urandom(), $urandom(), $urandom(), $urandom()});
    end
    in_valid = 1'b0;
    b2b      = 1'b0;
    wait_idle();
    check("t6_accepts_L1", 128'(acc_count[0]), 128'd17);

    repeat (3) @(posedge clk);
    for (int g = 0; g < ND; g++)
      check($sformatf("drain[L%0d]", 1 << g), 128'(exp_q[g].size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
